// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM state encoding and
// the prefetch-queue entry layout for the default PC/instruction widths.
package fetch_pkg;

  localparam int unsigned FETCH_PW = 8;
  localparam int unsigned FETCH_IW = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_PW-1:0] pc;
    logic [FETCH_IW-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush; DEPTH must be a power
// of two so the read/write pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/empty qualify every read,
  // so stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited in-order requests to imem,
// prefetch queue toward decode, redirect squash and halt.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned    PW       = 8,
  parameter int unsigned    IW       = 9,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [PW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          imem_req,
  output logic [PW-1:0] imem_addr,
  input  logic          imem_valid,
  input  logic [IW-1:0] imem_rdata,
  output logic          inst_valid,
  output logic [IW-1:0] inst,
  output logic [PW-1:0] inst_pc,
  input  logic          inst_ready,
  input  logic          redirect,
  input  logic [PW-1:0] redirect_pc,
  input  logic          halt,
  output logic          done
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [PW-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          run;
  logic          halt_now;
  logic          redir_now;
  logic          issue;
  logic          resp_keep;
  logic [CW:0]   credits_used;

  logic              q_push;
  logic              q_pop;
  logic              q_flush;
  logic              q_full;
  logic              q_empty;
  logic [CW-1:0]     q_count;
  logic [PW+IW-1:0]  q_wdata;
  logic [PW+IW-1:0]  q_rdata;

  assign run       = (state_q == RUN);
  assign halt_now  = run & halt;
  assign redir_now = run & redirect & ~halt;

  // Queued entries and outstanding requests share one pool of DEPTH credits,
  // so every response is guaranteed a free queue slot.
  assign credits_used = {1'b0, q_count} + {1'b0, inflight_q};
  assign issue        = run & ~halt & ~redirect & (credits_used < (CW+1)'(DEPTH));

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;

  assign resp_keep = imem_valid & (drop_q == '0);
  assign q_push    = run & ~halt & ~redirect & resp_keep;
  assign q_pop     = inst_ready;
  assign q_flush   = halt_now | redir_now;
  assign q_wdata   = {resp_pc_q, imem_rdata};

  sync_fifo #(
    .WIDTH (PW + IW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (q_flush),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign inst_valid = ~q_empty;
  assign inst       = q_empty ? '0 : q_rdata[IW-1:0];
  assign inst_pc    = q_empty ? '0 : q_rdata[PW+IW-1:IW];
  assign done       = (state_q == HALTED) & ~reset;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (halt)  state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + CW'(issue) - CW'(imem_valid);
    drop_d     = drop_q - CW'(imem_valid && (drop_q != '0));

    if ((state_q == IDLE) && start) begin
      fetch_pc_d = RESET_PC;
      resp_pc_d  = RESET_PC;
    end

    if (redir_now) begin
      // Everything already issued is wrong-path; a response arriving this
      // cycle is discarded by the flush and must not be counted twice.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_d     = inflight_q - CW'(imem_valid);
    end else begin
      if (issue)  fetch_pc_d = fetch_pc_q + 1'b1;
      if (q_push) resp_pc_d  = resp_pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(q_push && q_full))
        else $error("fetch_unit: push into full prefetch queue");
      assert (!(imem_valid && (inflight_q == '0)))
        else $error("fetch_unit: imem_valid with no request in flight");
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency memory model
// and logs of issued requests and delivered instructions.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int PW    = 8;
  localparam int IW    = 9;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_valid = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [PW-1:0] inst_pc;
  logic          inst_ready = 1'b1;
  logic          redirect = 1'b0;
  logic [PW-1:0] redirect_pc = '0;
  logic          halt = 1'b0;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  int t;
  logic [PW-1:0] exp_pc;

  int            pend_due[$];
  logic [PW-1:0] pend_addr[$];
  int            req_cyc[$];
  logic [PW-1:0] req_addr[$];
  fetch_entry_t  got[$];
  int            got_cyc[$];

  fetch_unit #(.PW(PW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [IW-1:0] mem_data(logic [PW-1:0] a);
    return {~a[0], a ^ 8'hA5};
  endfunction

  // Memory model and logging, evaluated mid-cycle when everything is stable.
  always @(negedge clk) begin
    imem_valid = 1'b0;
    if (reset) begin
      pend_due.delete();
      pend_addr.delete();
    end else begin
      if (imem_req) begin
        pend_due.push_back(cyc + mem_lat);
        pend_addr.push_back(imem_addr);
        req_cyc.push_back(cyc);
        req_addr.push_back(imem_addr);
      end
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        imem_valid = 1'b1;
        imem_rdata = mem_data(pend_addr[0]);
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
      end
      if (inst_valid && inst_ready) begin
        got.push_back('{pc: inst_pc, inst: inst});
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_logs();
    req_cyc.delete(); req_addr.delete(); got.delete(); got_cyc.delete();
  endtask

  task automatic pulse_start(output int ts);
    start = 1'b1;
    ts = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_got(int n, int budget, string tag);
    int k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_deliveries"}, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_imem_req"},   32'(imem_req),   32'd0);
    check({tag, "_imem_addr"},  32'(imem_addr),  32'h00);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_inst"},       32'(inst),       32'd0);
    check({tag, "_inst_pc"},    32'(inst_pc),    32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values, then streaming fetch at L=1
    mem_lat = 1; inst_ready = 1'b1;
    do_reset();
    clear_logs();
    check_idle_outputs("t1_reset");
    pulse_start(t);
    wait_got(6, 40, "t1");
    check("t1_first_req_cyc", 32'(req_cyc[0]), 32'(t + 1));
    check("t1_first_inst_cyc", 32'(got_cyc[0]), 32'(t + 3));
    for (int i = 0; i < 6; i++) begin
      check("t1_req_addr", 32'(req_addr[i]), 32'(i));
      check("t1_req_cyc",  32'(req_cyc[i]),  32'(t + 1 + i));
      check("t1_inst_pc",  32'(got[i].pc),   32'(i));
      check("t1_inst",     32'(got[i].inst), 32'(mem_data(8'(i))));
      check("t1_inst_cyc", 32'(got_cyc[i]),  32'(t + 3 + i));
    end

    // 2: decode stalled, credits cap the requests at DEPTH
    do_reset();
    inst_ready = 1'b0;
    clear_logs();
    pulse_start(t);
    tick(9);
    check("t2_req_count", 32'(req_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("t2_req_addr", 32'(req_addr[i]), 32'(i));
    check("t2_req_stalled", 32'(imem_req),   32'd0);
    check("t2_head_valid",  32'(inst_valid), 32'd1);
    check("t2_head_pc",     32'(inst_pc),    32'd0);
    check("t2_head_inst",   32'(inst),       32'(mem_data(8'h00)));
    clear_logs();
    inst_ready = 1'b1;
    wait_got(6, 40, "t2");
    for (int i = 0; i < 6; i++) begin
      check("t2_inst_pc", 32'(got[i].pc),   32'(i));
      check("t2_inst",    32'(got[i].inst), 32'(mem_data(8'(i))));
    end
    check("t2_resume_addr", 32'(req_addr[0]), 32'd4);

    // 3: redirect with two requests in flight at L=3
    do_reset();
    mem_lat = 3; inst_ready = 1'b1;
    clear_logs();
    pulse_start(t);
    tick(2);
    redirect = 1'b1; redirect_pc = 8'h40;
    #1;
    check("t3_no_req_redirect", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    wait_got(4, 40, "t3");
    check("t3_req_addr0",    32'(req_addr[0]), 32'h00);
    check("t3_req_addr1",    32'(req_addr[1]), 32'h01);
    check("t3_req_addr2",    32'(req_addr[2]), 32'h40);
    check("t3_req_cyc2",     32'(req_cyc[2]),  32'(t + 4));
    for (int i = 0; i < 4; i++) begin
      check("t3_inst_pc", 32'(got[i].pc),   32'(8'h40 + i));
      check("t3_inst",    32'(got[i].inst), 32'(mem_data(8'(8'h40 + i))));
    end

    // 4: redirect near the top of the address space wraps
    redirect = 1'b1; redirect_pc = 8'hFE;
    tick();
    redirect = 1'b0;
    got.delete(); got_cyc.delete();
    wait_got(4, 40, "t4");
    for (int i = 0; i < 4; i++) begin
      exp_pc = 8'hFE + 8'(i);
      check("t4_inst_pc", 32'(got[i].pc),   32'(exp_pc));
      check("t4_inst",    32'(got[i].inst), 32'(mem_data(exp_pc)));
    end

    // 5: halt wins over redirect; done sticks until reset
    halt = 1'b1; redirect = 1'b1; redirect_pc = 8'h10;
    #1;
    check("t5_no_req_halt", 32'(imem_req), 32'd0);
    tick();
    halt = 1'b0; redirect = 1'b0;
    clear_logs();
    check("t5_done",       32'(done),       32'd1);
    check("t5_inst_valid", 32'(inst_valid), 32'd0);
    check("t5_imem_req",   32'(imem_req),   32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(6);
    check("t5_done_held",   32'(done),            32'd1);
    check("t5_req_held",    32'(imem_req),        32'd0);
    check("t5_valid_held",  32'(inst_valid),      32'd0);
    check("t5_no_delivery", 32'(got.size()),      32'd0);
    check("t5_no_requests", 32'(req_addr.size()), 32'd0);
    reset = 1'b1;
    #1;
    check("t5_done_in_reset", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    check("t5_done_after_reset", 32'(done), 32'd0);

    // 6: reset with three in flight and one queued
    do_reset();
    mem_lat = 3; inst_ready = 1'b0;
    clear_logs();
    pulse_start(t);
    tick(4);
    check("t6_pre_valid", 32'(inst_valid), 32'd1);
    check("t6_pre_req",   32'(imem_req),   32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("t6_reset");
    mem_lat = 1; inst_ready = 1'b1;
    clear_logs();
    pulse_start(t);
    wait_got(3, 40, "t6");
    check("t6_first_inst_cyc", 32'(got_cyc[0]), 32'(t + 3));
    for (int i = 0; i < 3; i++) begin
      check("t6_inst_pc", 32'(got[i].pc),   32'(i));
      check("t6_inst",    32'(got[i].inst), 32'(mem_data(8'(i))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
